// File: rtl/fifo_pkg.sv
// Shared Fifo definitions: level type and read timing used by the Fifo
// block, its wrappers and the stream reader.
package fifo_pkg;

  // Occupancy of a 2-entry buffer (0..2).
  typedef logic [1:0] level_t;

  // Cycles between an accepted read request and readData_o being valid.
  localparam int unsigned READ_LATENCY = 1;

  // Output buffer depth; one slot covers the in-flight read, one the stall.
  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry shift buffer. buf0 is the head; a pop shifts buf1 into buf0
// and a push lands in the first slot left free after that pop.
module skid_buffer2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output level_t           count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  level_t           count_q, count_d;
  level_t           after_pop;
  logic [2:0]       count_sum;

  // Next buffer contents: shift on pop, then place any incoming item.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    after_pop = count_q - level_t'(pop_i);
    count_sum = 3'(count_q) + 3'(push_i) - 3'(pop_i);
    count_d   = count_sum[1:0];
    if (pop_i) begin
      buf0_d = buf1_q;
    end
    if (push_i) begin
      if (after_pop == '0) begin
        buf0_d = push_data_i;
      end else begin
        buf1_d = push_data_i;
      end
    end
  end

  // Buffer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      count_q <= '0;
    end else begin
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      count_q <= count_d;
    end
  end

  // The request logic upstream must never let occupancy pass the depth.
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_sum <= 3'(BUF_DEPTH));

  assign count_o = count_q;
  assign head_o  = buf0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a Fifo read port into a valid/ready stream. Requests are issued
// only when the 2-entry buffer can absorb every item already promised,
// so the one-cycle read latency is hidden without over-fetching.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             fifoReadEnable_o,
  input  logic [WIDTH-1:0] fifoReadData_i,
  input  logic             fifoReadBusy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       level_o
);

  logic       inflight_q, inflight_d;
  logic       pop;
  level_t     count;
  logic [2:0] demand;
  logic       read_en;

  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;

  // Request decision: buffered plus in-flight items after this pop must
  // leave a free slot. Reset gates the request combinationally.
  always_comb begin
    demand     = 3'(count) + 3'(inflight_q) - 3'(pop);
    read_en    = rst_ni && !fifoReadBusy_i && (demand < 3'(BUF_DEPTH));
    inflight_d = read_en;
  end

  // In-flight flag: data from last cycle's request arrives this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  skid_buffer2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i (fifoReadData_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (data_o)
  );

  assign fifoReadEnable_o = read_en;
  assign level_o          = count;

endmodule
